// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset sequencer.
// Used by multicycle_control and mc_opcode_class.
package mc_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        RST       = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        EXCEPT    = 4'd13
    } mc_state_e;

    // Opcodes understood by this datapath (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Memory access size
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Exception cause
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    // Access size from the low opcode bits of a load/store
    function automatic logic [1:0] size_from_op(input logic [1:0] op_lo);
        logic [1:0] size;
        case (op_lo)
            2'b11:   size = SIZE_WORD;
            2'b01:   size = SIZE_HALF;
            2'b00:   size = SIZE_BYTE;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: maps IR[31:26] to an instruction class
// and a memory access size. Kept separate so a pipelined decoder can reuse it.
module mc_opcode_class
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_jump,
    output logic       is_beq,
    output logic       is_addi,
    output logic       is_load,
    output logic       is_store,
    output logic       is_illegal,
    output logic [1:0] size
);

    // Classify the opcode; anything not listed is illegal
    always_comb begin
        is_rtype   = 1'b0;
        is_jump    = 1'b0;
        is_beq     = 1'b0;
        is_addi    = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE:            is_rtype   = 1'b1;
            OP_J:                is_jump    = 1'b1;
            OP_BEQ:              is_beq     = 1'b1;
            OP_ADDI:             is_addi    = 1'b1;
            OP_LB, OP_LH, OP_LW: is_load    = 1'b1;
            OP_SB, OP_SH, OP_SW: is_store   = 1'b1;
            default:             is_illegal = 1'b1;
        endcase
    end

    assign size = size_from_op(opcode[1:0]);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath (R-type, loads, stores,
// beq, j, addi). Outputs are a Moore decode of the state register; only the
// fetch/store completion enables also look at mem_ready.
// Optional build macro MC_MEM_TIMEOUT_EN: bounds memory waits and raises a
// bus-timeout exception after TIMEOUT_CYCLES stalled cycles.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_size,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       exception,
    output logic [1:0] exc_cause,
    output logic       instr_done
);

    mc_state_e  state_r;
    mc_state_e  state_next_s;
    logic [1:0] size_r;
    logic [1:0] exc_cause_r;
    logic [1:0] exc_cause_next_s;

    logic       cls_rtype_s;
    logic       cls_jump_s;
    logic       cls_beq_s;
    logic       cls_addi_s;
    logic       cls_load_s;
    logic       cls_store_s;
    logic       cls_illegal_s;
    logic [1:0] cls_size_s;

    logic       wait_state_s;
    logic       timeout_s;

    mc_opcode_class u_opcode_class (
        .opcode     (opcode),
        .is_rtype   (cls_rtype_s),
        .is_jump    (cls_jump_s),
        .is_beq     (cls_beq_s),
        .is_addi    (cls_addi_s),
        .is_load    (cls_load_s),
        .is_store   (cls_store_s),
        .is_illegal (cls_illegal_s),
        .size       (cls_size_s)
    );

    assign wait_state_s = (state_r == FETCH) || (state_r == MEM_READ) || (state_r == MEM_WRITE);

`ifdef MC_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_r;

    assign timeout_s = wait_state_s && !mem_ready &&
                       (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled cycles within one memory-wait state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (mem_ready) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (wait_state_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end
    end
`else
    // Waits are unbounded; the sizing parameters only matter for the timeout build
    localparam logic CFG_OK = ((64'd1 << CNT_W) > 64'(TIMEOUT_CYCLES));
    assign timeout_s = 1'b0 & CFG_OK;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the access size while the opcode is decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r <= SIZE_WORD;
        end else if (state_r == DECODE) begin
            size_r <= cls_size_s;
        end else begin
            size_r <= size_r;
        end
    end

    // Exception cause, held until the next exception or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_cause_r <= EXC_NONE;
        end else begin
            exc_cause_r <= exc_cause_next_s;
        end
    end

    assign exc_cause = exc_cause_r;

    // Next-state and Moore output decode
    always_comb begin
        state_next_s     = state_r;
        exc_cause_next_s = exc_cause_r;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        ir_write         = 1'b0;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_size         = SIZE_WORD;
        reg_write        = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_RT;
        alu_op           = ALU_ADD;
        pc_source        = PCSRC_ALU;
        exception        = 1'b0;
        instr_done       = 1'b0;

        case (state_r)
            RST: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (timeout_s) begin
                    state_next_s     = EXCEPT;
                    exc_cause_next_s = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut here
                alu_src_b = SRCB_IMM_SH2;
                if (cls_illegal_s) begin
                    state_next_s     = EXCEPT;
                    exc_cause_next_s = EXC_ILLEGAL;
                end else if (cls_rtype_s) begin
                    state_next_s = R_EXEC;
                end else if (cls_jump_s) begin
                    state_next_s = JUMP;
                end else if (cls_beq_s) begin
                    state_next_s = BRANCH;
                end else if (cls_addi_s) begin
                    state_next_s = I_EXEC;
                end else if (cls_load_s || cls_store_s) begin
                    state_next_s = MEM_ADDR;
                end else begin
                    state_next_s     = EXCEPT;
                    exc_cause_next_s = EXC_ILLEGAL;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode[3]) begin
                    state_next_s = MEM_WRITE;
                end else begin
                    state_next_s = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                mem_size = size_r;
                if (timeout_s) begin
                    state_next_s     = EXCEPT;
                    exc_cause_next_s = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_next_s = MEM_WB;
                end else begin
                    state_next_s = MEM_READ;
                end
            end
            MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                mem_size   = size_r;
                instr_done = mem_ready;
                if (timeout_s) begin
                    state_next_s     = EXCEPT;
                    exc_cause_next_s = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEM_WRITE;
                end
            end
            R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_RT;
                alu_op       = ALU_FUNCT;
                state_next_s = R_WB;
            end
            R_WB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                state_next_s = I_WB;
            end
            I_WB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RT;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_next_s  = FETCH;
            end
            JUMP: begin
                pc_write     = 1'b1;
                pc_source    = PCSRC_JUMP;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            EXCEPT: begin
                exception    = 1'b1;
                pc_write     = 1'b1;
                pc_source    = PCSRC_EXC;
                state_next_s = FETCH;
            end
            default: begin
                // Unused encodings recover through the reset state
                state_next_s = RST;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic [1:0] mem_size;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       exception;
    logic [1:0] exc_cause;
    logic       instr_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .exception     (exception),
        .exc_cause     (exc_cause),
        .instr_done    (instr_done)
    );

    // All control outputs except exc_cause, packed for whole-cycle comparison
    wire [19:0] out_vec = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                           mem_size, reg_write, reg_dst, mem_to_reg, alu_src_a,
                           alu_src_b, alu_op, pc_source, exception, instr_done};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pk(
        input logic pw, input logic pwc, input logic irw, input logic iod,
        input logic mr, input logic mw, input logic [1:0] ms,
        input logic rw, input logic rd, input logic m2r, input logic asa,
        input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] psrc,
        input logic exc, input logic idone);
        return {pw, pwc, irw, iod, mr, mw, ms, rw, rd, m2r, asa, asb, aop, psrc, exc, idone};
    endfunction

    // Hand-written expected output sets, one per state
    function automatic logic [19:0] e_fetch(input logic r);
        return pk(r, 1'b0, r, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] e_decode();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] e_addr();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] e_mrd(input logic [1:0] ms);
        return pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ms, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] e_mwb();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction
    function automatic logic [19:0] e_mwr(input logic [1:0] ms, input logic r);
        return pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ms, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, r);
    endfunction
    function automatic logic [19:0] e_rex();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] e_rwb();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction
    function automatic logic [19:0] e_iwb();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction
    function automatic logic [19:0] e_beq();
        return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1);
    endfunction
    function automatic logic [19:0] e_jmp();
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1);
    endfunction
    function automatic logic [19:0] e_exc();
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
    endfunction

    // One clock cycle: drive inputs, check outputs, advance to the next falling edge
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic [19:0] exp);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check_eq(tag, {12'd0, out_vec}, {12'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        @(negedge clk);

        // Reset state
        cyc("rst_hold", 6'b000000, 1'b1, 20'd0);
        check_eq("rst_exc_cause", {30'd0, exc_cause}, 32'd0);
        rst_n = 1'b1;
        cyc("rst_release", 6'b000000, 1'b1, 20'd0);

        // R-type
        cyc("r_fetch",  6'b000000, 1'b1, e_fetch(1'b1));
        cyc("r_decode", 6'b000000, 1'b1, e_decode());
        cyc("r_exec",   6'b000000, 1'b1, e_rex());
        cyc("r_wb",     6'b000000, 1'b1, e_rwb());

        // lh with three wait cycles in MEM_READ; MEM_WB is cycle 8
        cyc("lh_fetch",  6'b100001, 1'b1, e_fetch(1'b1));
        cyc("lh_decode", 6'b100001, 1'b1, e_decode());
        cyc("lh_addr",   6'b100001, 1'b1, e_addr());
        for (int i = 0; i < 3; i++) begin
            cyc("lh_read_wait", 6'b100001, 1'b0, e_mrd(2'b01));
        end
        cyc("lh_read_done", 6'b100001, 1'b1, e_mrd(2'b01));
        cyc("lh_wb",        6'b100001, 1'b1, e_mwb());

        // sb, zero wait
        cyc("sb_fetch",  6'b101000, 1'b1, e_fetch(1'b1));
        cyc("sb_decode", 6'b101000, 1'b1, e_decode());
        cyc("sb_addr",   6'b101000, 1'b1, e_addr());
        cyc("sb_write",  6'b101000, 1'b1, e_mwr(2'b10, 1'b1));

        // sw with one wait cycle
        cyc("sw_fetch",      6'b101011, 1'b1, e_fetch(1'b1));
        cyc("sw_decode",     6'b101011, 1'b1, e_decode());
        cyc("sw_addr",       6'b101011, 1'b1, e_addr());
        cyc("sw_write_wait", 6'b101011, 1'b0, e_mwr(2'b00, 1'b0));
        cyc("sw_write_done", 6'b101011, 1'b1, e_mwr(2'b00, 1'b1));

        // lw, fetch with one wait first
        cyc("lw_fetch_wait", 6'b100011, 1'b0, e_fetch(1'b0));
        cyc("lw_fetch",      6'b100011, 1'b1, e_fetch(1'b1));
        cyc("lw_decode",     6'b100011, 1'b1, e_decode());
        cyc("lw_addr",       6'b100011, 1'b1, e_addr());
        cyc("lw_read",       6'b100011, 1'b1, e_mrd(2'b00));
        cyc("lw_wb",         6'b100011, 1'b1, e_mwb());

        // addi
        cyc("addi_fetch",  6'b001000, 1'b1, e_fetch(1'b1));
        cyc("addi_decode", 6'b001000, 1'b1, e_decode());
        cyc("addi_exec",   6'b001000, 1'b1, e_addr());
        cyc("addi_wb",     6'b001000, 1'b1, e_iwb());

        // beq then j
        cyc("beq_fetch",  6'b000100, 1'b1, e_fetch(1'b1));
        cyc("beq_decode", 6'b000100, 1'b1, e_decode());
        cyc("beq_branch", 6'b000100, 1'b1, e_beq());
        cyc("j_fetch",    6'b000010, 1'b1, e_fetch(1'b1));
        cyc("j_decode",   6'b000010, 1'b1, e_decode());
        check_eq("pre_exc_cause", {30'd0, exc_cause}, 32'd0);
        cyc("j_jump",     6'b000010, 1'b1, e_jmp());

        // Illegal opcodes
        cyc("ill1_fetch",  6'b111111, 1'b1, e_fetch(1'b1));
        cyc("ill1_decode", 6'b111111, 1'b1, e_decode());
        check_eq("ill1_exc_cause", {30'd0, exc_cause}, 32'd1);
        cyc("ill1_except", 6'b111111, 1'b1, e_exc());
        cyc("ill2_fetch",  6'b100010, 1'b1, e_fetch(1'b1));
        cyc("ill2_decode", 6'b100010, 1'b1, e_decode());
        cyc("ill2_except", 6'b100010, 1'b1, e_exc());
        check_eq("ill2_exc_cause", {30'd0, exc_cause}, 32'd1);

        // Reset during MEM_READ
        cyc("rstm_fetch",  6'b100011, 1'b1, e_fetch(1'b1));
        cyc("rstm_decode", 6'b100011, 1'b1, e_decode());
        cyc("rstm_addr",   6'b100011, 1'b1, e_addr());
        cyc("rstm_read",   6'b100011, 1'b0, e_mrd(2'b00));
        rst_n = 1'b0;
        #1;
        check_eq("rstm_outputs",   {12'd0, out_vec}, 32'd0);
        check_eq("rstm_exc_cause", {30'd0, exc_cause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rstm_release", 6'b000000, 1'b1, 20'd0);

`ifdef MC_MEM_TIMEOUT_EN
        // Stuck fetch: four stalled cycles then a bus-timeout exception
        for (int i = 0; i < 4; i++) begin
            cyc("to_fetch_wait", 6'b000000, 1'b0, e_fetch(1'b0));
        end
        check_eq("to_exc_cause", {30'd0, exc_cause}, 32'd2);
        cyc("to_except",   6'b000000, 1'b0, e_exc());
        cyc("to_refetch",  6'b000000, 1'b1, e_fetch(1'b1));
        cyc("to_decode",   6'b000000, 1'b1, e_decode());
`else
        // Without the timeout the fetch waits indefinitely
        for (int i = 0; i < 6; i++) begin
            cyc("nto_fetch_wait", 6'b000000, 1'b0, e_fetch(1'b0));
        end
        check_eq("nto_exc_cause", {30'd0, exc_cause}, 32'd0);
        cyc("nto_fetch",  6'b000000, 1'b1, e_fetch(1'b1));
        cyc("nto_decode", 6'b000000, 1'b1, e_decode());
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: R-type, lb/lh/lw, sb/sh/sw, beq, j, addi.
- Replaces single-cycle decode so one shared ALU and one unified memory port serve fetch, address calculation and data access over several cycles.
- Sits between the instruction register (IR) opcode field and the datapath mux/enable inputs.
- Handshakes with memory through mem_ready.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive mem_ready-low cycles before a bus-timeout exception. Used only with MC_MEM_TIMEOUT_EN.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from the DECODE state onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- ir_write  out  1  latch fetched word into IR.
- i_or_d  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_size  out  2  access size: 00 = word, 01 = half, 10 = byte.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- exception  out  1  one-cycle pulse while in the EXCEPT state.
- exc_cause  out  2  01 = illegal opcode, 10 = bus timeout; held until the next exception.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Moore machine: every output decodes from registered state only (plus mem_ready for the fetch enables).
- Async reset: state goes to RST, size_q = 00, exc_cause = 00, timeout counter = 0.
- In RST all outputs are 0. The first clk edge after rst_n rises enters FETCH.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target).
  - Registers size_q from opcode[1:0]: 11 -> 00 (word), 01 -> 01 (half), 00 -> 10 (byte).
  - Next state by opcode:
    - 000000 -> R_EXEC.
    - 000010 -> JUMP.
    - 000100 -> BRANCH.
    - 001000 -> I_EXEC.
    - 100000, 100001, 100011, 101000, 101001, 101011 -> MEM_ADDR.
    - Anything else (including 100010 and 101010) -> EXCEPT with exc_cause=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if opcode[3]=0, otherwise MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1, mem_size=size_q. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, mem_size=size_q. instr_done=mem_ready. Goes to FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Then FETCH.
- EXCEPT: exception=1, pc_write=1, pc_source=11. Then FETCH. No instr_done.
- mem_size = 00 in every state except MEM_READ and MEM_WRITE.
- Latency with zero-wait memory, in cycles:
  - lw: 5.
  - R-type, addi, sw: 4.
  - beq, j, illegal opcode: 3.
  - Each mem_ready-low cycle adds one cycle.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- mem_read and mem_write are never both 1.
- Reset mid-instruction:
  - Immediate return to RST; in-flight memory request dropped combinationally.
  - No instr_done.
  - exc_cause clears.

Optional Feature:
- Macro: MC_MEM_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle the machine sits in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Counter clears on mem_ready=1 and on every state change.
  - When the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0, next state is EXCEPT and exc_cause becomes 10.
  - In a MEM_WRITE timeout no write is retired and instr_done stays 0.
- Undefined: no counter logic; waits are unbounded; exc_cause never takes 10.

Decomposition:
- Package mc_pkg holds:
  - state enum: RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, EXCEPT.
  - opcode constants.
  - encodings for alu_op, alu_src_b, pc_source, mem_size and exc_cause.
- One natural sub-module: mc_opcode_class, a combinational opcode-to-class decoder (rtype, jump, beq, addi, load, store, illegal; plus size). Reusable by a future pipelined decoder.

Test Plan:
- Reset then an R-type opcode 000000 with mem_ready tied 1:
  - States FETCH, DECODE, R_EXEC, R_WB.
  - reg_write=1 and reg_dst=1 only in cycle 4; instr_done pulses in cycle 4.
- lh (opcode 100001) with mem_ready held 0 for 3 cycles in MEM_READ:
  - mem_size=01 throughout those cycles, i_or_d=1.
  - MEM_WB reached 8 cycles after FETCH; mem_to_reg=1.
- sb (opcode 101000): mem_write=1 with mem_size=10 in cycle 4; no reg_write at any point.
- beq (opcode 000100) then j (opcode 000010):
  - beq: pc_write_cond=1 with pc_source=01 and alu_op=01 in cycle 3.
  - j: pc_write=1 with pc_source=10 in cycle 3.
- Illegal opcodes 111111 and 100010:
  - EXCEPT in cycle 3: exception=1, pc_source=11, exc_cause=01.
  - No instr_done; next cycle is FETCH.
- rst_n pulsed low during MEM_READ:
  - All outputs 0 immediately, exc_cause=00.
  - FETCH on the first edge after release.
  - With MC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready stuck at 0 in FETCH gives EXCEPT with exc_cause=10.
